// File: rtl/conv_weight_loader.sv
// conv_weight_loader: assembles a byte stream into conv weights, checks an XOR trailer, gates conv starts
module conv_weight_loader #(
  parameter int IN_CHANNELS       = 12,
  parameter int OUT_CHANNELS      = 12,
  parameter int KERNEL_SIZE       = 3,
  parameter int DATA_WIDTH        = 16,
  parameter int WEIGHT_ADDR_WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_start,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic [DATA_WIDTH-1:0]        weight_in,
  output logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr,
  output logic                         load_weights,
  output logic                         load_busy,
  output logic                         load_done,
  output logic                         load_error,
  input  logic                         run_req,
  output logic                         start_conv,
  input  logic                         conv_done,
  output logic                         conv_running
);
  localparam int TOTAL = IN_CHANNELS * OUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE + OUT_CHANNELS;
  typedef enum logic [2:0] {IDLE, LO, HI, WRITE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] lo_q, lo_d, csum_q, csum_d;
  logic [WEIGHT_ADDR_WIDTH-1:0] cnt_q, cnt_d, weight_addr_q, weight_addr_d;
  logic [DATA_WIDTH-1:0] weight_in_q, weight_in_d;
  logic load_weights_q, load_weights_d, load_done_q, load_done_d, load_error_q, load_error_d;
  logic start_conv_q, start_conv_d, conv_running_q, conv_running_d;
  logic acc;
  assign byte_ready   = state_q inside {LO, HI, CHECK};
  assign load_busy    = state_q inside {LO, HI, WRITE, CHECK};
  assign acc          = byte_valid && byte_ready;
  assign weight_in    = weight_in_q;
  assign weight_addr  = weight_addr_q;
  assign load_weights = load_weights_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign start_conv   = start_conv_q;
  assign conv_running = conv_running_q;
  // next state: load sequencing, word assembly, checksum, and conv start gating
  always_comb begin
    state_d        = state_q;
    lo_d           = lo_q;
    csum_d         = csum_q;
    cnt_d          = cnt_q;
    weight_in_d    = weight_in_q;
    weight_addr_d  = weight_addr_q;
    load_weights_d = 1'b0;
    load_done_d    = load_done_q;
    load_error_d   = load_error_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_start && !conv_running_q) begin
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          cnt_d        = '0;
          csum_d       = '0;
          state_d      = LO;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      LO: if (acc) begin
        lo_d    = byte_in;
        csum_d  = csum_q ^ byte_in;
        state_d = HI;
      end
      HI: if (acc) begin
        csum_d         = csum_q ^ byte_in;
        load_weights_d = 1'b1;
        weight_in_d    = DATA_WIDTH'({byte_in, lo_q});
        weight_addr_d  = cnt_q;
        state_d        = WRITE;
      end
      WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q < WEIGHT_ADDR_WIDTH'(TOTAL - 1)) ? LO : CHECK;
      end
      CHECK: if (acc) begin
        load_error_d = byte_in != csum_q;
        load_done_d  = 1'b1;
        state_d      = DONE;
      end
      default: state_d = IDLE;
    endcase
    start_conv_d   = run_req && load_done_q && !load_error_q && !load_busy && !conv_running_q && !start_conv_q;
    conv_running_d = conv_done ? 1'b0 : start_conv_q ? 1'b1 : conv_running_q;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lo_q           <= '0;
      csum_q         <= '0;
      cnt_q          <= '0;
      weight_in_q    <= '0;
      weight_addr_q  <= '0;
      load_weights_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      start_conv_q   <= 1'b0;
      conv_running_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lo_q           <= lo_d;
      csum_q         <= csum_d;
      cnt_q          <= cnt_d;
      weight_in_q    <= weight_in_d;
      weight_addr_q  <= weight_addr_d;
      load_weights_q <= load_weights_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
      start_conv_q   <= start_conv_d;
      conv_running_q <= conv_running_d;
    end
  end
endmodule

// File: tb/tb_conv_weight_loader.sv
// tb_conv_weight_loader: directed checks of weight loading, checksum, conv gating and reset
module tb_conv_weight_loader;
  localparam int TOTAL = 1308;
  logic clk = 1'b0, rst_n = 1'b0, load_start = 1'b0, byte_valid = 1'b0, run_req = 1'b0, conv_done = 1'b0;
  logic [7:0] byte_in = '0;
  logic byte_ready, load_weights, load_busy, load_done, load_error, start_conv, conv_running;
  logic [15:0] weight_in;
  logic [19:0] weight_addr;
  int n_cmp = 0, n_err = 0;
  int wr_cnt = 0, seq_err = 0, start_cnt = 0, last_addr = -1, next_addr = 0;
  bit chk_data = 1'b0;
  int w0, e0, s0;
  conv_weight_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .weight_in(weight_in), .weight_addr(weight_addr), .load_weights(load_weights),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error), .run_req(run_req),
    .start_conv(start_conv), .conv_done(conv_done), .conv_running(conv_running)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] pat(input int a);
    logic [31:0] p;
    p = a * 32'h9E37 ^ 32'h5A5A;
    return p[15:0];
  endfunction
  // write monitor: addresses must run 0,1,2... from each accepted load_start or reset
  always @(negedge clk) begin
    if (!rst_n) next_addr = 0;
    else begin
      if (load_start && !load_busy && !conv_running) next_addr = 0;
      if (load_weights) begin
        wr_cnt++;
        if (int'(weight_addr) != next_addr || (chk_data && weight_in !== pat(int'(weight_addr)))) seq_err++;
        last_addr = int'(weight_addr);
        next_addr = int'(weight_addr) + 1;
      end
      if (start_conv) start_cnt++;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input bit rnd);
    int t;
    if (rnd) repeat ($urandom_range(0, 2)) begin
      byte_valid = 1'b0;
      byte_in = 8'($urandom);
      tick();
    end
    byte_in = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("byte_ready_timeout", 32'(t), 32'(0));
    tick();
  endtask
  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask
  task automatic load_all(input logic [7:0] flip, input bit rnd, input bit mid);
    logic [7:0] x;
    logic [15:0] d;
    x = '0;
    pulse_start();
    for (int w = 0; w < TOTAL; w++) begin
      d = pat(w);
      send(d[7:0], rnd);
      send(d[15:8], rnd);
      x ^= d[7:0] ^ d[15:8];
      if (mid && w == 600) begin
        byte_valid = 1'b0;
        pulse_start();
      end
    end
    send(x ^ flip, rnd);
    byte_valid = 1'b0;
  endtask
  initial begin
    repeat (2) tick();
    check("rst_busy", 32'(load_busy), 0);
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_addr", 32'(weight_addr), 0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    check("busy_after_start", 32'(load_busy), 1);
    send(8'h34, 1'b0);
    send(8'h12, 1'b0);
    check("first_we", 32'(load_weights), 1);
    check("first_data", 32'(weight_in), 32'h1234);
    check("first_addr", 32'(weight_addr), 0);
    check("ready_in_write", 32'(byte_ready), 0);
    byte_valid = 1'b0;
    tick();
    check("we_one_cycle", 32'(load_weights), 0);
    check("addr_held", 32'(weight_addr), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_data = 1'b1;
    w0 = wr_cnt; e0 = seq_err;
    load_all(8'h00, 1'b0, 1'b0);
    check("good_writes", 32'(wr_cnt - w0), 32'(TOTAL));
    check("good_seq", 32'(seq_err - e0), 0);
    check("good_last_addr", 32'(last_addr), 32'(TOTAL - 1));
    check("good_done", 32'(load_done), 1);
    check("good_error", 32'(load_error), 0);
    check("good_busy", 32'(load_busy), 0);
    repeat (2) tick();
    s0 = start_cnt;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("start_pulse", 32'(start_conv), 1);
    check("running_not_yet", 32'(conv_running), 0);
    tick();
    check("start_one_cycle", 32'(start_conv), 0);
    check("running_set", 32'(conv_running), 1);
    tick();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (2) tick();
    check("second_req_dropped", 32'(start_cnt - s0), 1);
    pulse_start();
    check("start_ignored_running", 32'(load_busy), 0);
    check("done_kept_running", 32'(load_done), 1);
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    check("running_cleared", 32'(conv_running), 0);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("restart_pulse", 32'(start_conv), 1);
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    check("done_priority", 32'(conv_running), 0);
    tick();
    check("done_priority_hold", 32'(conv_running), 0);
    check("two_starts_total", 32'(start_cnt - s0), 2);
    w0 = wr_cnt; e0 = seq_err;
    load_all(8'h00, 1'b1, 1'b1);
    check("rnd_writes", 32'(wr_cnt - w0), 32'(TOTAL));
    check("rnd_seq", 32'(seq_err - e0), 0);
    check("rnd_last_addr", 32'(last_addr), 32'(TOTAL - 1));
    check("rnd_done", 32'(load_done), 1);
    check("rnd_error", 32'(load_error), 0);
    w0 = wr_cnt; e0 = seq_err;
    load_all(8'h01, 1'b0, 1'b0);
    check("bad_writes", 32'(wr_cnt - w0), 32'(TOTAL));
    check("bad_done", 32'(load_done), 1);
    check("bad_error", 32'(load_error), 1);
    repeat (2) tick();
    s0 = start_cnt;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (2) tick();
    check("bad_no_start", 32'(start_cnt - s0), 0);
    pulse_start();
    for (int w = 0; w < 500; w++) begin
      send(pat(w)[7:0], 1'b0);
      send(pat(w)[15:8], 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(load_busy), 0);
    check("arst_ready", 32'(byte_ready), 0);
    check("arst_addr", 32'(weight_addr), 0);
    check("arst_data", 32'(weight_in), 0);
    check("arst_we", 32'(load_weights), 0);
    check("arst_done", 32'(load_done), 0);
    check("arst_error", 32'(load_error), 0);
    check("arst_conv", 32'({start_conv, conv_running}), 0);
    byte_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abandoned_done", 32'(load_done), 0);
    check("abandoned_busy", 32'(load_busy), 0);
    e0 = seq_err;
    pulse_start();
    for (int w = 0; w < 2; w++) begin
      send(pat(w)[7:0], 1'b0);
      send(pat(w)[15:8], 1'b0);
    end
    byte_valid = 1'b0;
    check("restart_addr", 32'(weight_addr), 1);
    check("restart_seq", 32'(seq_err - e0), 0);
    check("restart_busy", 32'(load_busy), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
